vga_scan_ctrl: RTL and testbench



---
 rtl/vga_scan_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_vga_scan_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl
//   VGA read-side scan controller for the 256x240 NES frame buffer.
//   Generates 640x480@60 timing, the frame-buffer read address, a 2-stage
//   pixel pipeline (data capture, registered palette lookup) and the syncs.
//   The picture is upscaled 2x into a 512x480 window starting at X_OFFSET.
//
// Ports
//   clk, rst              single clock, synchronous active-high reset
//   pix_en                pixel-rate enable; all state advances only when high
//   vga_row, vga_col      frame-buffer read address (col 511 = out of frame)
//   vga_data              frame-buffer read data for the current address
//   hsync, vsync          syncs, active level SYNC_POL, aligned with colour
//   red, green, blue      4-bit colour channels
//   vblank                high while the line counter is in vertical blanking
//   frame_start           one-clock pulse on the tick that enters vblank
//
// Build option
//   VGA_SCANLINE_EN       when defined, odd output lines are drawn at half
//                         intensity (each channel shifted right by one).

module vga_scan_ctrl #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned X_OFFSET  = 64,
  parameter logic        SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  output logic [9:0] vga_row,
  output logic [9:0] vga_col,
  input  logic [7:0] vga_data,
  output logic       hsync,
  output logic       vsync,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       vblank,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned IMG_W   = 512;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] V_VIS_LAST = 10'(V_VISIBLE - 1);
  localparam logic [9:0] IMG_LO = 10'(X_OFFSET);
  localparam logic [9:0] IMG_HI = 10'(X_OFFSET + IMG_W);
  localparam logic [9:0] HS_LO  = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_HI  = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_LO  = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_HI  = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic       h_last;

  // Stage-0 (combinational) signals
  logic       in_img;
  logic       active;
  logic       hs_act;
  logic       vs_act;
  logic [9:0] hrel;

  // Stage-1 registers
  logic       s1_valid;
  logic [5:0] s1_idx;
  logic       s1_show;
  logic       s1_hs;
  logic       s1_vs;
  logic [11:0] pix_rgb;

  logic unused_bits;

  // ---------------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------------
  assign h_last = (hcnt == H_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
      end else begin
        hcnt <= hcnt + 10'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 0: read address and raw timing flags
  // ---------------------------------------------------------------------------
  assign hrel   = hcnt - IMG_LO;
  assign in_img = (hcnt >= IMG_LO) && (hcnt < IMG_HI) && (vcnt < V_VIS);
  assign active = (hcnt < H_VIS) && (vcnt < V_VIS);
  assign hs_act = (hcnt >= HS_LO) && (hcnt < HS_HI);
  assign vs_act = (vcnt >= VS_LO) && (vcnt < VS_HI);

  assign vga_row = {1'b0, vcnt[9:1]};
  assign vga_col = in_img ? {1'b0, hrel[9:1]} : 10'd511;

  assign unused_bits = ^{vga_data[7:6], hrel[0]};

  // ---------------------------------------------------------------------------
  // Palette (NES 2C02, reduced to 4 bits per channel)
  // ---------------------------------------------------------------------------
  function automatic logic [11:0] nes_palette(input logic [5:0] idx);
    logic [11:0] c;
    case (idx)
      6'h00: c = 12'h777; 6'h01: c = 12'h00F; 6'h02: c = 12'h00B; 6'h03: c = 12'h42B;
      6'h04: c = 12'h908; 6'h05: c = 12'hA02; 6'h06: c = 12'hA10; 6'h07: c = 12'h810;
      6'h08: c = 12'h530; 6'h09: c = 12'h070; 6'h0A: c = 12'h060; 6'h0B: c = 12'h050;
      6'h0C: c = 12'h045; 6'h0D: c = 12'h000; 6'h0E: c = 12'h000; 6'h0F: c = 12'h000;
      6'h10: c = 12'hBBB; 6'h11: c = 12'h07F; 6'h12: c = 12'h05F; 6'h13: c = 12'h64F;
      6'h14: c = 12'hD0C; 6'h15: c = 12'hE05; 6'h16: c = 12'hF30; 6'h17: c = 12'hE51;
      6'h18: c = 12'hA70; 6'h19: c = 12'h0B0; 6'h1A: c = 12'h0A0; 6'h1B: c = 12'h0A4;
      6'h1C: c = 12'h088; 6'h1D: c = 12'h000; 6'h1E: c = 12'h000; 6'h1F: c = 12'h000;
      6'h20: c = 12'hFFF; 6'h21: c = 12'h3BF; 6'h22: c = 12'h68F; 6'h23: c = 12'h97F;
      6'h24: c = 12'hF7F; 6'h25: c = 12'hF59; 6'h26: c = 12'hF75; 6'h27: c = 12'hFA4;
      6'h28: c = 12'hFB0; 6'h29: c = 12'hBF1; 6'h2A: c = 12'h5D5; 6'h2B: c = 12'h5F9;
      6'h2C: c = 12'h0ED; 6'h2D: c = 12'h777; 6'h2E: c = 12'h000; 6'h2F: c = 12'h000;
      6'h30: c = 12'hFFF; 6'h31: c = 12'hAEF; 6'h32: c = 12'hBBF; 6'h33: c = 12'hDBF;
      6'h34: c = 12'hFBF; 6'h35: c = 12'hFAC; 6'h36: c = 12'hFDB; 6'h37: c = 12'hFEA;
      6'h38: c = 12'hFD7; 6'h39: c = 12'hDF7; 6'h3A: c = 12'hBFB; 6'h3B: c = 12'hBFD;
      6'h3C: c = 12'h0FF; 6'h3D: c = 12'hFDF; 6'h3E: c = 12'h000; default: c = 12'h000;
    endcase
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage 1 capture and stage 2 output registers
  // ---------------------------------------------------------------------------
`ifdef VGA_SCANLINE_EN
  logic s1_odd;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_odd <= 1'b0;
    end else if (pix_en) begin
      s1_odd <= vcnt[0];
    end
  end

  always_comb begin
    pix_rgb = nes_palette(s1_idx);
    if (s1_odd) begin
      pix_rgb = {1'b0, pix_rgb[11:9], 1'b0, pix_rgb[7:5], 1'b0, pix_rgb[3:1]};
    end
  end
`else
  always_comb begin
    pix_rgb = nes_palette(s1_idx);
  end
`endif

  // Borders inside the visible area are blanked here as well, so the picture
  // stays black there even if the buffer does not return index 0x3F.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_show  <= 1'b0;
      s1_hs    <= 1'b0;
      s1_vs    <= 1'b0;
      hsync    <= ~SYNC_POL;
      vsync    <= ~SYNC_POL;
      red      <= '0;
      green    <= '0;
      blue     <= '0;
    end else if (pix_en) begin
      s1_valid <= 1'b1;
      s1_idx   <= vga_data[5:0];
      s1_show  <= active && in_img;
      s1_hs    <= hs_act;
      s1_vs    <= vs_act;
      if (s1_valid) begin
        hsync <= s1_hs ? SYNC_POL : ~SYNC_POL;
        vsync <= s1_vs ? SYNC_POL : ~SYNC_POL;
        {red, green, blue} <= s1_show ? pix_rgb : '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame status for the PPU side (not delayed with the pixel pipeline)
  // ---------------------------------------------------------------------------
  assign vblank = (vcnt >= V_VIS);

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && h_last && (vcnt == V_VIS_LAST);
    end
  end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb_vga_scan_ctrl
//   Self-checking bench for vga_scan_ctrl. The vertical timing is shortened
//   through parameter overrides so several whole frames fit in a short run;
//   horizontal timing and the image window keep their real values.
//   A combinational frame-buffer stub answers the DUT address; a reference
//   model built from the raster rules predicts every output on every clock.

module tb_vga_scan_ctrl;

  localparam int HV  = 640;
  localparam int HFP = 16;
  localparam int HS  = 96;
  localparam int HBP = 48;
  localparam int VV  = 6;
  localparam int VFP = 2;
  localparam int VS  = 2;
  localparam int VBP = 2;
  localparam int XO  = 64;
  localparam int HT  = HV + HFP + HS + HBP;
  localparam int VT  = VV + VFP + VS + VBP;

  logic       clk = 1'b0;
  logic       rst;
  logic       pix_en;
  logic [9:0] vga_row;
  logic [9:0] vga_col;
  logic [7:0] vga_data;
  logic       hsync;
  logic       vsync;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic       vblank;
  logic       frame_start;

  int         mode;
  logic [7:0] seed;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  vga_scan_ctrl #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .X_OFFSET(XO), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .vga_row(vga_row), .vga_col(vga_col), .vga_data(vga_data),
    .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue),
    .vblank(vblank), .frame_start(frame_start)
  );

  logic [11:0] pal [64] = '{
    12'h777, 12'h00F, 12'h00B, 12'h42B, 12'h908, 12'hA02, 12'hA10, 12'h810,
    12'h530, 12'h070, 12'h060, 12'h050, 12'h045, 12'h000, 12'h000, 12'h000,
    12'hBBB, 12'h07F, 12'h05F, 12'h64F, 12'hD0C, 12'hE05, 12'hF30, 12'hE51,
    12'hA70, 12'h0B0, 12'h0A0, 12'h0A4, 12'h088, 12'h000, 12'h000, 12'h000,
    12'hFFF, 12'h3BF, 12'h68F, 12'h97F, 12'hF7F, 12'hF59, 12'hF75, 12'hFA4,
    12'hFB0, 12'hBF1, 12'h5D5, 12'h5F9, 12'h0ED, 12'h777, 12'h000, 12'h000,
    12'hFFF, 12'hAEF, 12'hBBF, 12'hDBF, 12'hFBF, 12'hFAC, 12'hFDB, 12'hFEA,
    12'hFD7, 12'hDF7, 12'hBFB, 12'hBFD, 12'h0FF, 12'hFDF, 12'h000, 12'h000
  };

  // Frame-buffer stub: 0 = column pattern, 1 = all 0x30, 2 = all 0x3F,
  // 3 = pseudo-random per address. Out-of-frame columns read as 0x3F.
  function automatic logic [7:0] stub_data(input int m, input logic [9:0] row,
                                           input logic [9:0] col, input logic [7:0] sd);
    if (col >= 10'd256) return 8'h3F;
    case (m)
      0:       return col[7:0];
      1:       return 8'h30;
      2:       return 8'h3F;
      default: return 8'(int'(col) * 37 + int'(row) * 11) ^ sd;
    endcase
  endfunction

  assign vga_data = stub_data(mode, vga_row, vga_col, seed);

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } pix_t;

  localparam pix_t IDLE = '{hs: 1'b1, vs: 1'b1, rgb: 12'h000};

  int   mh;
  int   mv;
  pix_t pq [$];
  pix_t m_out;
  logic m_fs;

  function automatic logic in_image(input int h, input int v);
    return (h >= XO) && (h < XO + 512) && (v < VV);
  endfunction

  function automatic int exp_col(input int h, input int v);
    return in_image(h, v) ? (h - XO) / 2 : 511;
  endfunction

  function automatic pix_t pix_of(input int h, input int v);
    pix_t        p;
    logic [7:0]  d;
    logic [11:0] c;
    d = stub_data(mode, 10'(v / 2), 10'(exp_col(h, v)), seed);
    c = in_image(h, v) ? pal[d[5:0]] : 12'h000;
`ifdef VGA_SCANLINE_EN
    if (v % 2 == 1) c = {c[11:8] / 4'd2, c[7:4] / 4'd2, c[3:0] / 4'd2};
`endif
    p.hs  = !((h >= HV + HFP) && (h < HV + HFP + HS));
    p.vs  = !((v >= VV + VFP) && (v < VV + VFP + VS));
    p.rgb = c;
    return p;
  endfunction

  task automatic model_edge(input logic r, input logic pe);
    if (r) begin
      mh = 0;
      mv = 0;
      pq.delete();
      m_fs  = 1'b0;
      m_out = IDLE;
    end else if (pe) begin
      pq.push_back(pix_of(mh, mv));
      if (pq.size() > 2) void'(pq.pop_front());
      if (pq.size() == 2) m_out = pq[0];
      m_fs = (mh == HT - 1) && (mv == VV - 1);
      mh++;
      if (mh == HT) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end
    end else begin
      m_fs = 1'b0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h (h=%0d v=%0d)", tag, obs, exp, mh, mv);
    end
  endtask

  task automatic compare();
    check("vga_row", 32'(vga_row), 32'(mv / 2));
    check("vga_col", 32'(vga_col), 32'(exp_col(mh, mv)));
    check("hsync", 32'(hsync), 32'(m_out.hs));
    check("vsync", 32'(vsync), 32'(m_out.vs));
    check("rgb", 32'({red, green, blue}), 32'(m_out.rgb));
    check("vblank", 32'(vblank), 32'(mv >= VV));
    check("frame_start", 32'(frame_start), 32'(m_fs));
  endtask

  task automatic step(input logic r, input logic pe);
    rst    = r;
    pix_en = pe;
    @(posedge clk);
    model_edge(r, pe);
    @(negedge clk);
    compare();
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence with randomized data and enables
  // ---------------------------------------------------------------------------
  int hs_low;
  int vs_low;
  int fs_cnt;

  initial begin
    rst    = 1'b1;
    pix_en = 1'b0;
    mode   = 0;
    seed   = 8'($urandom);
    m_out  = IDLE;
    m_fs   = 1'b0;
    mh     = 0;
    mv     = 0;
    @(negedge clk);

    // Reset with pix_en high, then one full frame of column-pattern data
    repeat (3) step(1'b1, 1'b1);
    hs_low = 0;
    vs_low = 0;
    fs_cnt = 0;
    for (int i = 0; i < HT * VT; i++) begin
      step(1'b0, 1'b1);
      if (i < HT && hsync === 1'b0) hs_low++;
      if (vsync === 1'b0) vs_low++;
      if (frame_start === 1'b1) fs_cnt++;
    end
    check("hsync_low_ticks_per_line", 32'(hs_low), 32'(HS));
    check("vsync_low_ticks_per_frame", 32'(vs_low), 32'(VS * HT));
    check("frame_start_per_frame_full_rate", 32'(fs_cnt), 32'd1);
    repeat (400) step(1'b0, 1'b1);

    // White data, random enable, reset mid-frame
    mode = 1;
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000 || i == 2001) step(1'b1, 1'($urandom_range(0, 1)));
      else                        step(1'b0, 1'($urandom_range(0, 1)));
    end

    // Black (0x3F) data at full rate
    mode = 2;
    repeat (1700) step(1'b0, 1'b1);

    // Random data, enable every fourth clock over more than one frame
    mode = 3;
    seed = 8'($urandom);
    repeat (2) step(1'b1, 1'b0);
    fs_cnt = 0;
    for (int i = 0; i < 4 * (HT * VT + 100); i++) begin
      step(1'b0, (i % 4) == 3);
      if (frame_start === 1'b1) fs_cnt++;
    end
    check("frame_start_per_frame_quarter_rate", 32'(fs_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
